decouple_controller: RTL and testbench

- Sequencer directly upstream of decouple_pipeline. It drives decouple_control and consumes the returned decouple_status.
- Converts a level request from the host register block into a safe decouple/recouple handshake for a reconfigurable partition.
- Before reporting decoupled, it waits for the pipelined status and for in-flight partition transactions to drain, with a bounded timeout.

---
 rtl/decouple_controller_if.sv | 65 ++++++
 rtl/decouple_controller.sv | 201 ++++++++++++++++++++
 tb/tb_decouple_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decouple_controller_if.sv
// -----------------------------------------------------------------------------
// decouple_controller_if
//
// Purpose:
//   Bundles the request, transaction-tracking, status and error signals that
//   pass between the host side (register block, partition transaction monitor
//   and decouple_pipeline) and decouple_controller.
//
// Modports:
//   master - host side. Drives req_decouple, txn_start, txn_done,
//            decouple_status and clear_err. Observes every controller output.
//   slave  - decouple_controller. Consumes the host-side signals and drives
//            decouple_control, decoupled, coupled, outstanding, timeout_err
//            and count_err.
//
// Parameter:
//   OUTSTANDING_W - width of the outstanding-transaction count. It must match
//                   the controller instance that is attached.
// -----------------------------------------------------------------------------
interface decouple_controller_if #(
  parameter int OUTSTANDING_W = 8
);

  logic                     req_decouple;
  logic                     txn_start;
  logic                     txn_done;
  logic                     decouple_status;
  logic                     clear_err;

  logic                     decouple_control;
  logic                     decoupled;
  logic                     coupled;
  logic [OUTSTANDING_W-1:0] outstanding;
  logic                     timeout_err;
  logic                     count_err;

  modport master (
    output req_decouple,
    output txn_start,
    output txn_done,
    output decouple_status,
    output clear_err,
    input  decouple_control,
    input  decoupled,
    input  coupled,
    input  outstanding,
    input  timeout_err,
    input  count_err
  );

  modport slave (
    input  req_decouple,
    input  txn_start,
    input  txn_done,
    input  decouple_status,
    input  clear_err,
    output decouple_control,
    output decoupled,
    output coupled,
    output outstanding,
    output timeout_err,
    output count_err
  );

endinterface

// File: rtl/decouple_controller.sv
// -----------------------------------------------------------------------------
// decouple_controller
//
// Purpose:
//   Sequences the decouple/recouple handshake for a reconfigurable partition.
//   The host gives a level request. The controller drives decouple_control
//   into decouple_pipeline and then waits for the pipelined copy to return on
//   decouple_status. When decoupling, it also waits for in-flight partition
//   transactions to drain. That drain wait is bounded by DRAIN_TIMEOUT.
//
// Ports:
//   clk    - clock. All logic is updated on the rising edge.
//   reset  - asynchronous, active-high reset.
//   bus    - decouple_controller_if.slave:
//              req_decouple     in   1 = decouple partition, 0 = couple
//              txn_start        in   pulse per transaction issued
//              txn_done         in   pulse per transaction completed
//              decouple_status  in   pipelined copy of decouple_control
//              clear_err        in   clears both sticky error flags
//              decouple_control out  registered decouple command
//              decoupled        out  high only in DECOUPLED
//              coupled          out  high only in COUPLED
//              outstanding      out  in-flight transaction count
//              timeout_err      out  sticky: drain timeout forced decouple
//              count_err        out  sticky: counter over/underflow attempted
//
// Parameters:
//   DRAIN_TIMEOUT - cycles allowed in WAIT_DEC before completion is forced.
//                   Must be >= 1.
//   OUTSTANDING_W - width of the outstanding-transaction counter.
// -----------------------------------------------------------------------------
module decouple_controller #(
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int OUTSTANDING_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  decouple_controller_if.slave   bus
);

  localparam int TIMER_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]       TIMER_MAX  = TIMER_W'(DRAIN_TIMEOUT);
  localparam logic [TIMER_W-1:0]       TIMER_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [OUTSTANDING_W-1:0] CNT_MAX    = '1;
  localparam logic [OUTSTANDING_W-1:0] CNT_ONE    = OUTSTANDING_W'(1);
  localparam logic [TIMER_W-1:0]       TIMER_ONE  = TIMER_W'(1);

  typedef enum logic [1:0] {
    ST_COUPLED   = 2'd0,
    ST_WAIT_DEC  = 2'd1,
    ST_DECOUPLED = 2'd2,
    ST_WAIT_COUP = 2'd3
  } state_t;

  state_t                   state_q,       state_d;
  logic                     ctrl_q,        ctrl_d;
  logic                     decoupled_q,   decoupled_d;
  logic                     coupled_q,     coupled_d;
  logic [OUTSTANDING_W-1:0] outstanding_q, outstanding_d;
  logic [TIMER_W-1:0]       timer_q,       timer_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     count_err_q,   count_err_d;

  logic force_clear;
  logic timeout_set;
  logic count_set;

  // State transitions and the drain timer.
  // The timeout comparison uses >= rather than ==. The timer saturates, so if
  // decouple_status is still low when the drain window ends, the timeout
  // stays armed and fires as soon as the status returns. It does not
  // deadlock.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    force_clear = 1'b0;
    timeout_set = 1'b0;

    case (state_q)
      ST_COUPLED: begin
        if (bus.req_decouple) begin
          state_d = ST_WAIT_DEC;
          timer_d = '0;
        end
      end

      ST_WAIT_DEC: begin
        if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TIMER_ONE;
        end
        if (bus.decouple_status && (outstanding_q == '0)) begin
          state_d = ST_DECOUPLED;
        end else if (bus.decouple_status && (timer_q >= TIMER_LAST)) begin
          state_d     = ST_DECOUPLED;
          timeout_set = 1'b1;
          force_clear = 1'b1;
        end
      end

      ST_DECOUPLED: begin
        if (!bus.req_decouple) begin
          state_d = ST_WAIT_COUP;
        end
      end

      ST_WAIT_COUP: begin
        if (!bus.decouple_status) begin
          state_d = ST_COUPLED;
        end
      end

      default: begin
        state_d = ST_DECOUPLED;
      end
    endcase
  end

  // The outputs are derived from the next state, so they are registered and
  // change together with the state itself. The command is high whenever the
  // controller is heading towards, or sitting in, the decoupled condition.
  always_comb begin
    ctrl_d      = (state_d == ST_WAIT_DEC) || (state_d == ST_DECOUPLED);
    decoupled_d = (state_d == ST_DECOUPLED);
    coupled_d   = (state_d == ST_COUPLED);
  end

  // Outstanding-transaction counter. A forced clear on timeout overrides that
  // cycle's start/done pulses. Overflow and underflow hold the count and flag
  // the error.
  always_comb begin
    outstanding_d = outstanding_q;
    count_set     = 1'b0;

    if (force_clear) begin
      outstanding_d = '0;
    end else if (bus.txn_start && !bus.txn_done) begin
      if (outstanding_q == CNT_MAX) begin
        count_set = 1'b1;
      end else begin
        outstanding_d = outstanding_q + CNT_ONE;
      end
    end else if (bus.txn_done && !bus.txn_start) begin
      if (outstanding_q == '0) begin
        count_set = 1'b1;
      end else begin
        outstanding_d = outstanding_q - CNT_ONE;
      end
    end
  end

  // Sticky error flags. A new error in the same cycle as clear_err is kept,
  // so that no event is lost.
  always_comb begin
    timeout_err_d = timeout_err_q;
    count_err_d   = count_err_q;

    if (timeout_set) begin
      timeout_err_d = 1'b1;
    end else if (bus.clear_err) begin
      timeout_err_d = 1'b0;
    end

    if (count_set) begin
      count_err_d = 1'b1;
    end else if (bus.clear_err) begin
      count_err_d = 1'b0;
    end
  end

  // Single state register. The reset value is DECOUPLED with the command
  // high, which matches the reset value of decouple_pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_DECOUPLED;
      ctrl_q        <= 1'b1;
      decoupled_q   <= 1'b1;
      coupled_q     <= 1'b0;
      outstanding_q <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      count_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      decoupled_q   <= decoupled_d;
      coupled_q     <= coupled_d;
      outstanding_q <= outstanding_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
      count_err_q   <= count_err_d;
    end
  end

  assign bus.decouple_control = ctrl_q;
  assign bus.decoupled        = decoupled_q;
  assign bus.coupled          = coupled_q;
  assign bus.outstanding      = outstanding_q;
  assign bus.timeout_err      = timeout_err_q;
  assign bus.count_err        = count_err_q;

endmodule

// File: tb/tb_decouple_controller.sv
// -----------------------------------------------------------------------------
// tb_decouple_controller
//
// Purpose:
//   Self-checking bench for decouple_controller. The main instance uses
//   DRAIN_TIMEOUT = 16 and an 8-bit counter. Its decouple_status comes from
//   a two-stage model of decouple_pipeline. A second instance, with a 2-bit
//   counter, exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_decouple_controller;

  logic clk;
  logic reset;

  int checks;
  int failures;

  decouple_controller_if #(.OUTSTANDING_W(8)) if1 ();
  decouple_controller_if #(.OUTSTANDING_W(2)) if2 ();

  decouple_controller #(
    .DRAIN_TIMEOUT(16),
    .OUTSTANDING_W(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (if1.slave)
  );

  decouple_controller #(
    .DRAIN_TIMEOUT(16),
    .OUTSTANDING_W(2)
  ) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of decouple_pipeline with depth 2. It resets to the decoupled
  // value.
  logic pipe_s1, pipe_s2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_s1 <= 1'b1;
      pipe_s2 <= 1'b1;
    end else begin
      pipe_s1 <= if1.decouple_control;
      pipe_s2 <= pipe_s1;
    end
  end
  assign if1.decouple_status = pipe_s2;

  // The second instance only needs a status that eventually follows its
  // command, so a single register stage is enough.
  logic pipe2;
  always @(posedge clk or posedge reset) begin
    if (reset) pipe2 <= 1'b1;
    else       pipe2 <= if2.decouple_control;
  end
  assign if2.decouple_status = pipe2;

  typedef struct {
    logic       req;
    logic       st;
    logic       dn;
    logic       clr;
    logic       e_ctrl;
    logic       e_dec;
    logic       e_coup;
    logic [7:0] e_out;
    logic       e_terr;
    logic       e_cerr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic req, st, dn, clr,
                        input logic e_ctrl, e_dec, e_coup,
                        input logic [7:0] e_out,
                        input logic e_terr, e_cerr);
    vec_t v;
    v.req = req; v.st = st; v.dn = dn; v.clr = clr;
    v.e_ctrl = e_ctrl; v.e_dec = e_dec; v.e_coup = e_coup;
    v.e_out = e_out; v.e_terr = e_terr; v.e_cerr = e_cerr;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs on the falling edge. Return 1 time unit after
  // the next rising edge, when the registered outputs are stable.
  task automatic applyStimulus(input logic req, st, dn, clr);
    @(negedge clk);
    if1.req_decouple = req;
    if1.txn_start    = st;
    if1.txn_done     = dn;
    if1.clear_err    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic e_ctrl, e_dec, e_coup,
                             input logic [7:0] e_out,
                             input logic e_terr, e_cerr);
    checks++;
    if ({if1.decouple_control, if1.decoupled, if1.coupled, if1.outstanding,
         if1.timeout_err, if1.count_err} !==
        {e_ctrl, e_dec, e_coup, e_out, e_terr, e_cerr}) begin
      failures++;
      $display("[TB] FAIL %s: got ctrl=%0b dec=%0b coup=%0b out=%0d terr=%0b cerr=%0b, expected ctrl=%0b dec=%0b coup=%0b out=%0d terr=%0b cerr=%0b",
               name, if1.decouple_control, if1.decoupled, if1.coupled,
               if1.outstanding, if1.timeout_err, if1.count_err,
               e_ctrl, e_dec, e_coup, e_out, e_terr, e_cerr);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    if1.req_decouple = 1'b1;
    if1.txn_start    = 1'b0;
    if1.txn_done     = 1'b0;
    if1.clear_err    = 1'b0;
    if2.req_decouple = 1'b1;
    if2.txn_start    = 1'b0;
    if2.txn_done     = 1'b0;
    if2.clear_err    = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_values", 1, 1, 0, 8'd0, 0, 0);

    // Request held high after reset: nothing may move.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("hold_decoupled", 1, 1, 0, 8'd0, 0, 0);
    end

    // Vector table: req st dn clr | ctrl dec coup out terr cerr
    // Couple with D=2: control drops after one cycle, coupled after four.
    addVec(0,0,0,0, 0,0,0,8'd0,0,0);
    addVec(0,0,0,0, 0,0,0,8'd0,0,0);
    addVec(0,0,0,0, 0,0,0,8'd0,0,0);
    addVec(0,0,0,0, 0,0,1,8'd0,0,0);
    // Three transactions issued while coupled.
    addVec(0,1,0,0, 0,0,1,8'd1,0,0);
    addVec(0,1,0,0, 0,0,1,8'd2,0,0);
    addVec(0,1,0,0, 0,0,1,8'd3,0,0);
    // Decouple request, then the three transactions drain.
    addVec(1,0,0,0, 1,0,0,8'd3,0,0);
    addVec(1,0,1,0, 1,0,0,8'd2,0,0);
    addVec(1,0,1,0, 1,0,0,8'd1,0,0);
    addVec(1,0,1,0, 1,0,0,8'd0,0,0);
    addVec(1,0,0,0, 1,1,0,8'd0,0,0);
    // Counter behaviour while decoupled.
    addVec(1,1,0,0, 1,1,0,8'd1,0,0);
    addVec(1,1,0,0, 1,1,0,8'd2,0,0);
    addVec(1,1,0,0, 1,1,0,8'd3,0,0);
    addVec(1,1,0,0, 1,1,0,8'd4,0,0);
    addVec(1,1,0,0, 1,1,0,8'd5,0,0);
    addVec(1,1,1,0, 1,1,0,8'd5,0,0);
    addVec(1,0,1,0, 1,1,0,8'd4,0,0);
    addVec(1,0,1,0, 1,1,0,8'd3,0,0);
    addVec(1,0,1,0, 1,1,0,8'd2,0,0);
    addVec(1,0,1,0, 1,1,0,8'd1,0,0);
    addVec(1,0,1,0, 1,1,0,8'd0,0,0);
    addVec(1,0,1,0, 1,1,0,8'd0,0,1);
    addVec(1,0,0,1, 1,1,0,8'd0,0,0);
    addVec(1,0,1,1, 1,1,0,8'd0,0,1);
    addVec(1,0,0,1, 1,1,0,8'd0,0,0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].st, vecs[i].dn, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_ctrl, vecs[i].e_dec,
                  vecs[i].e_coup, vecs[i].e_out, vecs[i].e_terr,
                  vecs[i].e_cerr);
    end

    // Drain timeout: one transaction never completes.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("to_coupled", 0, 0, 1, 8'd0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("to_one_txn", 0, 0, 1, 8'd1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("to_entry", 1, 0, 0, 8'd1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 0, 0, 0);
      if (i == 16) checkOutput("to_fire", 1, 1, 0, 8'd0, 1, 0);
      else         checkOutput("to_wait", 1, 0, 0, 8'd1, 0, 0);
    end
    applyStimulus(1, 0, 0, 1);
    checkOutput("to_clear", 1, 1, 0, 8'd0, 0, 0);

    // Request toggled low two cycles into WAIT_DEC.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("tg_coupled", 0, 0, 1, 8'd0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("tg_entry", 1, 0, 0, 8'd0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("tg_wait1", 1, 0, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tg_wait2", 1, 0, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tg_decoupled", 1, 1, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tg_wait_coup", 0, 0, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tg_wait_coup2", 0, 0, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tg_wait_coup3", 0, 0, 0, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tg_coupled_end", 0, 0, 1, 8'd0, 0, 0);

    // Build up some state, then reset asynchronously inside WAIT_COUP.
    applyStimulus(0, 1, 0, 0);
    checkOutput("rs_txn", 0, 0, 1, 8'd1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("rs_done", 0, 0, 1, 8'd0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("rs_underflow", 0, 0, 1, 8'd0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rs_entry", 1, 0, 0, 8'd0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rs_decoupled", 1, 1, 0, 8'd0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rs_wait_coup", 0, 0, 0, 8'd1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rs_wait_coup2", 0, 0, 0, 8'd1, 0, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rs_async", 1, 1, 0, 8'd0, 0, 0);
    @(negedge clk);
    if1.req_decouple = 1'b1;
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("rs_after", 1, 1, 0, 8'd0, 0, 0);

    // Two-bit counter saturates at 3.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if2.txn_start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({if2.outstanding, if2.count_err} !==
          {(i > 3) ? 2'd3 : 2'(i), (i == 4)}) begin
        failures++;
        $display("[TB] FAIL sat_w2_%0d: got out=%0d cerr=%0b, expected out=%0d cerr=%0b",
                 i, if2.outstanding, if2.count_err,
                 (i > 3) ? 3 : i, (i == 4));
      end
    end
    @(negedge clk);
    if2.txn_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
